// File: rtl/frame_reg_bank.sv
// Avalon-MM register bank with hardware-owned words, a frame status word and an export image.
// Define FRAME_REG_BANK_DBUF_EN to double-buffer software words so they change only at VS fall.
module frame_reg_bank #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 5,
  parameter logic [NUM_REGS-1:0] HW_MASK = NUM_REGS'(16'h03F0)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     AVL_CS,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic [ADDR_W-1:0]        AVL_ADDR,
  input  logic [3:0]               AVL_BYTE_EN,
  input  logic [31:0]              AVL_WRITEDATA,
  output logic [31:0]              AVL_READDATA,
  input  logic                     FRAME_VS,
  input  logic [NUM_REGS-1:0]      HW_WE,
  input  logic [32*NUM_REGS-1:0]   HW_WDATA,
  output logic [32*NUM_REGS-1:0]   EXPORT_REGS,
  output logic                     FRAME_PULSE
);

  logic [31:0] act_q [NUM_REGS];
  logic [31:0] act_d [NUM_REGS];
`ifdef FRAME_REG_BANK_DBUF_EN
  logic [31:0] pend_q [NUM_REGS];
  logic [31:0] pend_d [NUM_REGS];
`endif
  logic [31:0] rdata_q, rdata_d;
  logic        pulse_q, pulse_d;
  logic        vs_q, vs_d;
  logic        armed_q, armed_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flag_q, flag_d;

  logic wr, rd, commit, status_sel;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  assign wr         = AVL_CS & AVL_WRITE;
  assign rd         = AVL_CS & AVL_READ;
  assign status_sel = (AVL_ADDR == ADDR_W'(NUM_REGS));
  // armed_q blocks a commit when reset releases with VS already low
  assign commit     = armed_q & vs_q & ~FRAME_VS;

  always_comb begin
    act_d   = act_q;
`ifdef FRAME_REG_BANK_DBUF_EN
    pend_d  = pend_q;
`endif
    rdata_d = '0;
    pulse_d = commit;
    vs_d    = FRAME_VS;
    armed_d = armed_q | FRAME_VS;
    cnt_d   = commit ? cnt_q + 16'd1 : cnt_q;
    flag_d  = flag_q;

    if (commit) begin
      flag_d = 1'b1;
    end else if (wr && status_sel && AVL_BYTE_EN[0] && AVL_WRITEDATA[0]) begin
      flag_d = 1'b0;
    end

    if (rd && status_sel) rdata_d = {cnt_q, 15'b0, flag_q};

    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (HW_MASK[i]) begin
        if (HW_WE[i]) act_d[i] = HW_WDATA[32*i +: 32];
        if (rd && AVL_ADDR == ADDR_W'(i)) rdata_d = act_q[i];
      end else begin
`ifdef FRAME_REG_BANK_DBUF_EN
        if (commit) act_d[i] = pend_q[i];
        if (wr && AVL_ADDR == ADDR_W'(i)) pend_d[i] = merge_bytes(pend_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
        if (rd && AVL_ADDR == ADDR_W'(i)) rdata_d = pend_q[i];
`else
        if (wr && AVL_ADDR == ADDR_W'(i)) act_d[i] = merge_bytes(act_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
        if (rd && AVL_ADDR == ADDR_W'(i)) rdata_d = act_q[i];
`endif
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      act_q   <= '{default: '0};
`ifdef FRAME_REG_BANK_DBUF_EN
      pend_q  <= '{default: '0};
`endif
      rdata_q <= '0;
      pulse_q <= 1'b0;
      vs_q    <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      act_q   <= act_d;
`ifdef FRAME_REG_BANK_DBUF_EN
      pend_q  <= pend_d;
`endif
      rdata_q <= rdata_d;
      pulse_q <= pulse_d;
      vs_q    <= vs_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    EXPORT_REGS = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) EXPORT_REGS[32*i +: 32] = act_q[i];
  end

  assign AVL_READDATA = rdata_q;
  assign FRAME_PULSE  = pulse_q;

endmodule

// File: doc/frame_reg_bank.md
# frame_reg_bank

Parametrised Avalon-MM slave register bank between the Nios II bus and the game-engine/VGA logic. It generalises the fixed 16×32 game register file in four ways:
- configurable depth;
- correct per-byte write enables;
- per-register hardware ownership;
- frame-synchronous double buffering, so sprite/position registers change only at vertical sync.

It exports the active register image to the render pipeline and exposes a frame status/counter word to software.

## Interface
Parameters:
- NUM_REGS, 16, number of 32-bit registers; 1..2**ADDR_W-1.
- ADDR_W, 5, Avalon word-address width; address NUM_REGS is the status word.
- HW_MASK, 16'h03F0, bit i=1 makes register i hardware-owned.

Ports:
- CLK  in  1  system clock (50 MHz).
- RESET  in  1  asynchronous, active-high reset.
- AVL_CS  in  1  chip select.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_BYTE_EN  in  4  byte enables.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data, fixed read latency 1.
- FRAME_VS  in  1  VGA vertical sync, active low.
- HW_WE  in  NUM_REGS  per-register hardware write strobe.
- HW_WDATA  in  32*NUM_REGS  hardware write data; register i uses bits [32i+31:32i].
- EXPORT_REGS  out  32*NUM_REGS  active image; register i uses bits [32i+31:32i].
- FRAME_PULSE  out  1  one-cycle commit indicator.

## Operation
- Software-owned register i (HW_MASK[i]=0):
  - Holds a pending word and an active word.
  - Avalon write (AVL_CS && AVL_WRITE, AVL_ADDR=i) updates byte k of the pending word iff AVL_BYTE_EN[k]; byte k maps to bits [8k+7:8k].
  - Reads return the pending word.
- Hardware-owned register i (HW_MASK[i]=1):
  - Single word, loaded from HW_WDATA slice when HW_WE[i]=1.
  - Software writes are ignored.
  - Reads and the export both return this word directly, with no buffering.
- HW_WE[i] on a software-owned register is ignored.
- Commit:
  - vs_q is FRAME_VS registered; reset value 1.
  - commit = vs_q & ~FRAME_VS, i.e. the falling edge of vertical sync.
  - On a commit edge, every software-owned active word ← its pending word, and FRAME_PULSE=1 for that cycle.
- Status word (address NUM_REGS), read: {frame_cnt[15:0], 15'b0, frame_flag}.
  - frame_cnt increments on each commit and wraps 0xFFFF→0.
  - frame_flag sets on commit.
  - A write to NUM_REGS with BYTE_EN[0]=1 and WRITEDATA[0]=1 clears frame_flag (write-1-to-clear). Other status bits are read-only.
- Unmapped addresses (>NUM_REGS): reads return 0; writes are ignored.
- Simultaneous events:
  - Software write and commit in the same cycle: active takes the old pending value; the new value reaches active at the next commit.
  - Flag clear and commit in the same cycle: the flag stays 1 and the counter increments.
  - AVL_READ and AVL_WRITE together at the same address: read returns the pre-write value.

## Timing
- Reset (asynchronous):
  - All pending, active and hardware words = 0.
  - AVL_READDATA=0, FRAME_PULSE=0, frame_cnt=0, frame_flag=0, vs_q=1.
- Read: AVL_READDATA is registered and valid in cycle N+1 for a read in cycle N. It is 0 in any cycle following a non-read cycle. No wait states.
- Write: the pending/hardware word is visible to a read issued in the cycle after the write.
- Export: hardware-owned words appear on EXPORT_REGS the cycle after HW_WE. Software-owned words appear the cycle after the commit edge.
- FRAME_PULSE is registered: high in the cycle after the commit is detected, exactly 1 cycle wide.
- Reset deasserted while FRAME_VS=0: no commit until a fresh 1→0 transition.

## Configuration
- FRAME_REG_BANK_DBUF_EN defined:
  - Double buffering as above.
- Undefined:
  - No pending bank is instantiated.
  - Software writes update the active word directly; EXPORT_REGS changes the cycle after the write.
  - Reads return the active word.
  - The commit still drives FRAME_PULSE, frame_cnt and frame_flag.

## Test plan
Defaults NUM_REGS=16, ADDR_W=5, HW_MASK=16'h03F0, FRAME_REG_BANK_DBUF_EN defined.
- Reset → EXPORT_REGS all 0; read of addr 3 returns 0x00000000 one cycle later; status read returns 0x00000000.
- Write 0xAABBCCDD to addr 2 with BYTE_EN=4'b0101 → read returns 0x00BB00DD while export slice 2 is still 0. Drive FRAME_VS 1→0 → export slice 2 = 0x00BB00DD, FRAME_PULSE one cycle, status = 0x00010001.
- Write 0xFFFFFFFF to addr 5, then HW_WE[5]=1 with slice 5 = 0x00000123 → read addr 5 = 0x00000123; export slice 5 = 0x123 without any commit.
- Write 0x11 to addr 0 on the commit cycle → export slice 0 stays at its old value; equals 0x11 after the next VS falling edge.
- Write 0x1 to status on a commit cycle → flag remains 1. A later write of 0x1 with no commit → status bit 0 = 0 and the counter is unchanged.
- Assert RESET mid-frame after writes → all outputs 0 immediately (asynchronous); a read of addr 0 after release returns 0.
